seg7_pattern_reader: RTL and testbench

- Reads a 7-segment drive pattern from input pins, the receiving end of our segment-driver tiles, and decodes it back to a hex digit.
- Synchronises the pins and waits until the pattern has held steady for a programmable number of cycles.
- On a steady pattern: decodes it, flags patterns it does not recognise, pulses a strobe, and counts accepted digits.
- Used as a loopback checker and a display-to-logic bridge between tiles.

---
 rtl/seg7_pattern_reader_if.sv | 26 ++
 rtl/seg7_pattern_reader.sv | 130 +++++++++++++
 tb/tb_seg7_pattern_reader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pattern_reader_if.sv
// Bus between a 7-segment pattern source and the seg7_pattern_reader decoder.
// The optional dp_out signal exists only when SEG7_READER_DP_EN is defined.
interface seg7_pattern_reader_if #(
   parameter int CNT_W = 8
);
   logic [7:0]       seg_in;
   logic [3:0]       digit;
   logic             digit_valid;
   logic             blank;
   logic             bad_pattern;
   logic             new_digit;
   logic [CNT_W-1:0] digit_count;
`ifdef SEG7_READER_DP_EN
   logic             dp_out;

   modport master (output seg_in, input digit, digit_valid, blank, bad_pattern,
                   new_digit, digit_count, dp_out);
   modport slave  (input seg_in, output digit, digit_valid, blank, bad_pattern,
                   new_digit, digit_count, dp_out);
`else
   modport master (output seg_in, input digit, digit_valid, blank, bad_pattern,
                   new_digit, digit_count);
   modport slave  (input seg_in, output digit, digit_valid, blank, bad_pattern,
                   new_digit, digit_count);
`endif
endinterface

// File: rtl/seg7_pattern_reader.sv
// Decodes a synchronised, debounced 7-segment pattern back to a hex digit.
// Optional macro SEG7_READER_DP_EN adds dp_out and makes the dp bit part of the stability check.
module seg7_pattern_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   seg7_pattern_reader_if.slave    bus
);
   typedef enum logic [1:0] {ST_BLANK, ST_SETTLING, ST_LOCKED, ST_ERROR} state_e;

   localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 1);
`ifdef SEG7_READER_DP_EN
   localparam logic [7:0] CMP_MASK = 8'hFF;
`else
   localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

   logic [7:0]       s1_q, s2_q, prev_q, stab_q, stab_d;
   state_e           state_q, state_d, kind_q, shown;
   logic [3:0]       digit_q;
   logic             new_digit_q;
   logic [CNT_W-1:0] count_q;
   logic             changed, accept, dec_legal, dec_blank;
   logic [3:0]       dec_digit;

   // Returns {legal, digit} for the seven segment bits.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h3F: decode = {1'b1, 4'h0};
         7'h06: decode = {1'b1, 4'h1};
         7'h5B: decode = {1'b1, 4'h2};
         7'h4F: decode = {1'b1, 4'h3};
         7'h66: decode = {1'b1, 4'h4};
         7'h6D: decode = {1'b1, 4'h5};
         7'h7D: decode = {1'b1, 4'h6};
         7'h07: decode = {1'b1, 4'h7};
         7'h7F: decode = {1'b1, 4'h8};
         7'h6F: decode = {1'b1, 4'h9};
         7'h77: decode = {1'b1, 4'hA};
         7'h7C: decode = {1'b1, 4'hB};
         7'h39: decode = {1'b1, 4'hC};
         7'h5E: decode = {1'b1, 4'hD};
         7'h79: decode = {1'b1, 4'hE};
         7'h71: decode = {1'b1, 4'hF};
         default: decode = 5'h00;
      endcase
   endfunction

   assign {dec_legal, dec_digit} = decode(s2_q[6:0]);
   assign dec_blank = (s2_q[6:0] == 7'h00);
   assign changed   = (s2_q != prev_q);
   // Fires only on the step into saturation, so a held pattern is accepted once.
   assign accept    = !changed && (stab_q == STAB_PRE);

   always_comb begin
      stab_d = stab_q;
      if (changed)
         stab_d = 8'd0;
      else if (stab_q != STAB_MAX)
         stab_d = stab_q + 8'd1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_BLANK;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (changed)
         state_d = ST_SETTLING;
      else if (accept) begin
         if (dec_blank)      state_d = ST_BLANK;
         else if (dec_legal) state_d = ST_LOCKED;
         else                state_d = ST_ERROR;
      end
   end

   // Output logic: while settling, the flags reflect the last accepted pattern.
   always_comb begin
      shown = (state_q == ST_SETTLING) ? kind_q : state_q;
      bus.digit_valid = (shown == ST_LOCKED);
      bus.blank       = (shown == ST_BLANK);
      bus.bad_pattern = (shown == ST_ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 8'h00;
         s2_q        <= 8'h00;
         prev_q      <= 8'h00;
         stab_q      <= STAB_MAX;
         kind_q      <= ST_BLANK;
         digit_q     <= 4'h0;
         new_digit_q <= 1'b0;
         count_q     <= '0;
      end else begin
         s1_q        <= bus.seg_in & CMP_MASK;
         s2_q        <= s1_q;
         prev_q      <= s2_q;
         stab_q      <= stab_d;
         new_digit_q <= accept && !dec_blank && dec_legal;
         if (accept) begin
            kind_q <= state_d;
            if (!dec_blank && dec_legal) begin
               digit_q <= dec_digit;
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

`ifdef SEG7_READER_DP_EN
   logic dp_q;
   always_ff @(posedge clk) begin
      if (rst)         dp_q <= 1'b0;
      else if (accept) dp_q <= s2_q[7];
   end
   assign bus.dp_out = dp_q;
`endif

   assign bus.digit       = digit_q;
   assign bus.new_digit   = new_digit_q;
   assign bus.digit_count = count_q;
endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Randomised scoreboard bench for seg7_pattern_reader: a history-based model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_seg7_pattern_reader;
   localparam int S  = 4;
   localparam int CW = 8;
   localparam int HN = S + 4;

   typedef struct packed {
      logic [3:0]    digit;
      logic          valid;
      logic          blank;
      logic          bad;
      logic          nd;
      logic [CW-1:0] cnt;
      logic          dp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   exp_t exp_q[$];

   seg7_pattern_reader_if #(.CNT_W(CW)) bus ();
   seg7_pattern_reader #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: sample history plus the last accepted result.
   logic [7:0] hist [HN];
   exp_t       m;

   function automatic logic [7:0] mask(input logic [7:0] v);
`ifdef SEG7_READER_DP_EN
      return v;
`else
      return {1'b0, v[6:0]};
`endif
   endfunction

   task automatic model_edge(input logic [7:0] seg, input logic r);
      logic [7:0] v;
      logic       same;
      int         idx;
      if (r) begin
         for (int i = 0; i < HN; i++) hist[i] = 8'h00;
         m = '{digit: 4'h0, valid: 1'b0, blank: 1'b1, bad: 1'b0, nd: 1'b0, cnt: '0, dp: 1'b0};
         return;
      end
      for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = mask(seg);
      m.nd = 1'b0;
      // The pattern reaching the compare now must be its (S+1)th equal sample in a row.
      v = hist[2];
      same = 1'b1;
      for (int i = 2; i <= 2 + S; i++) if (hist[i] != v) same = 1'b0;
      if (same && hist[3+S] != v) begin
         m.dp = v[7];
         idx = -1;
         for (int k = 0; k < 16; k++) if (tbl[k] == v[6:0]) idx = k;
         if (v[6:0] == 7'h00) begin
            m.blank = 1'b1; m.valid = 1'b0; m.bad = 1'b0;
         end else if (idx >= 0) begin
            m.digit = 4'(idx); m.valid = 1'b1; m.blank = 1'b0; m.bad = 1'b0;
            m.nd = 1'b1; m.cnt = m.cnt + 1'b1;
         end else begin
            m.bad = 1'b1; m.valid = 1'b0; m.blank = 1'b0;
         end
      end
   endtask

   task automatic step(input logic [7:0] seg, input logic r);
      exp_t e;
      bus.seg_in = seg;
      rst = r;
      @(posedge clk);
      #1;
      cyc++;
      model_edge(seg, r);
      e = m;
`ifndef SEG7_READER_DP_EN
      e.dp = 1'b0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic [7:0] seg, input int n);
      for (int i = 0; i < n; i++) step(seg, 1'b0);
   endtask

   // Monitor: pops one expectation per cycle and compares the whole output set.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.digit = bus.digit;
            a.valid = bus.digit_valid;
            a.blank = bus.blank;
            a.bad   = bus.bad_pattern;
            a.nd    = bus.new_digit;
            a.cnt   = bus.digit_count;
`ifdef SEG7_READER_DP_EN
            a.dp    = bus.dp_out;
`else
            a.dp    = 1'b0;
`endif
            n_total++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL outputs cyc=%0d got dig=%h v=%b bl=%b bad=%b nd=%b cnt=%0d dp=%b want dig=%h v=%b bl=%b bad=%b nd=%b cnt=%0d dp=%b",
                        cyc, a.digit, a.valid, a.blank, a.bad, a.nd, a.cnt, a.dp,
                        e.digit, e.valid, e.blank, e.bad, e.nd, e.cnt, e.dp);
            end else if (a.nd) begin
               $display("txn cyc=%0d digit=%h count=%0d", cyc, a.digit, a.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d got pending=%0d want 0", cyc, exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      int         k, prev_k;
      logic [7:0] v;
      for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
      hold(8'h00, 20);
      // Directed: accept, glitch, illegal, dp change, reset mid-settle.
      hold(8'h4F, 10);
      hold(8'h06, 2);
      hold(8'h4F, 10);
      hold(8'h55, 10);
      hold(8'h3F, 10);
      hold(8'hBF, 10);
      hold(8'h00, 8);
      hold(8'h5B, 3);
      step(8'h5B, 1'b1);
      hold(8'h5B, 10);
      // Random mix of legal, blank and arbitrary patterns with short and long holds.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0, 1: begin k = $urandom_range(0, 15); v = {1'b0, tbl[k]}; end
            2:    v = 8'h00;
            default: v = 8'($urandom_range(0, 255));
         endcase
         v[7] = 1'($urandom_range(0, 1));
         hold(v, $urandom_range(1, 9));
      end
      // Enough distinct legal acceptances to wrap the counter.
      prev_k = 0;
      for (int i = 0; i < 260; i++) begin
         k = (prev_k + $urandom_range(1, 15)) % 16;
         prev_k = k;
         hold({1'b0, tbl[k]}, $urandom_range(6, 8));
      end
      hold(8'h00, 10);
      step(8'h00, 1'b1);
      hold(8'h00, 5);
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got pending=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
